demux8_rr_sched: RTL
====================

# demux8_rr_sched

Sequencing controller for the 1:8 demultiplexer datapath. Accepts a stream of words on a valid/ready input and delivers each word to exactly one of eight output lanes, chosen by round-robin over enabled lanes or by an explicit destination field. Holds one word in an output register, drives the lane select and a one-hot per-lane valid, and waits for that lane's ready. Sits between a single producer and eight lane consumers, replacing a free-running select.

## Interface
- DATA_W, 8, width of data words
- CNT_W, 16, width of delivered-word counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  producer has a word
- in_ready  out  1  block accepts the word this cycle
- in_data  in  DATA_W  word
- in_dest  in  3  destination lane, used only when rr_mode=0
- rr_mode  in  1  1 = round-robin lane choice, 0 = directed by in_dest
- lane_en  in  8  per-lane enable mask
- out_data  out  DATA_W  registered word, shared by all lanes
- out_sel  out  3  registered lane index of held word
- out_valid  out  8  one-hot; bit out_sel set while a word is held
- out_ready  in  8  per-lane consumer ready
- xfer_cnt  out  CNT_W  words delivered since reset, wraps
- drop_cnt  out  CNT_W  directed words dropped for a disabled lane, wraps

## Operation
- FSM states: IDLE (no word held), HOLD (word held in out_data/out_sel).
- Target lane at acceptance: rr_mode=1 -> first enabled lane searching ptr, ptr+1, ... ptr+7 (mod 8); rr_mode=0 -> in_dest.
- in_ready: rr_mode=1 -> (|lane_en) and (IDLE or delivery this cycle); rr_mode=0 -> IDLE or delivery this cycle.
- Delivery = HOLD and out_ready[out_sel]; increments xfer_cnt.
- Accept = in_valid and in_ready. Round-robin: load out_data/out_sel, ptr <= lane+1 mod 8. Directed to enabled lane: load. Directed to disabled lane: word consumed, not loaded, drop_cnt increments, ptr unchanged.
- Transitions: IDLE -accept(loaded)-> HOLD; HOLD -delivery, no load-> IDLE; HOLD -delivery and load-> HOLD with new word (back-to-back); otherwise stay.
- out_valid = HOLD ? (1 << out_sel) : 0.
- A held word is committed: clearing lane_en[out_sel] or toggling rr_mode while in HOLD does not cancel or redirect it.
- lane_en all zero in rr_mode=1: in_ready=0, ptr frozen, held word still delivered.
- ptr only advances on round-robin loads; directed loads leave it unchanged.
- Counters wrap from 2^CNT_W-1 to 0.

## Timing
- Reset (async assert, sync release): state IDLE, ptr=0, out_data=0, out_sel=0, out_valid=0, xfer_cnt=0, drop_cnt=0. in_ready is forced 0 while rst_n=0.
- Latency: word accepted at edge N is on out_data/out_valid from edge N to delivery; earliest delivery at edge N+1.
- Throughput: one word per clock when the selected lane keeps out_ready high.
- in_ready, delivery decision and round-robin pick are combinational from current state and inputs; all outputs except in_ready are registered.
- Reset mid-HOLD discards the held word; no delivery is counted.

## Structure
- Package demux8_sched_pkg: NUM_LANES=8, SEL_W=3, state enum {IDLE, HOLD}.
- Sub-module rr_pick8: inputs req[7:0], ptr[2:0]; outputs found, idx[2:0]; purely combinational rotate-priority search. Top holds FSM, registers, counters.

## Test plan
- Reset then lane_en=8'hFF, rr_mode=1, out_ready=8'hFF, stream 0x10..0x19 -> out_sel 0,1,...,7,0,1, one word per clock, xfer_cnt=10.
- lane_en=8'b1010_0100, rr_mode=1, 5 words -> lanes 2,5,7,2,5; ptr after last = 6.
- Held word 0xAA on lane 3, out_ready[3]=0 for 4 cycles -> out_valid=8'h08 stable, in_ready=0, no other lane asserted; out_ready[3]=1 -> delivered, next word loaded same edge.
- rr_mode=0, in_dest=6, lane_en[6]=0, word 0x55 -> in_ready=1, drop_cnt=1, out_valid stays 0, xfer_cnt unchanged.
- lane_en=0 in rr_mode=1 with in_valid=1 -> in_ready=0 indefinitely; held word on lane 1 still delivers when out_ready[1]=1.
- Assert rst_n=0 asynchronously while HOLD on lane 4 -> out_valid=0, out_sel=0, counters 0 immediately, before next clk edge.

Source files
------------

// File: rtl/demux8_sched_pkg.sv
// Shared definitions for the 1:8 demultiplexer sequencing controller.
//   NUM_LANES       : number of output lanes
//   SEL_W           : width of a lane index
//   sched_state_e   : controller state (IDLE = nothing held, HOLD = word held)
//   lane_onehot()   : lane index to one-hot lane vector
package demux8_sched_pkg;

    localparam int NUM_LANES = 8;
    localparam int SEL_W     = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } sched_state_e;

    function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [SEL_W-1:0] sel);
        return {{(NUM_LANES-1){1'b0}}, 1'b1} << sel;
    endfunction

endpackage

// File: rtl/demux8_sched_rr_pick8.sv
// Rotate-priority search over eight request bits, purely combinational.
//   req   [7:0] in  : candidate lanes
//   ptr   [2:0] in  : lane searched first; search continues ptr+1 .. ptr+7 (mod 8)
//   found       out : at least one request present
//   idx   [2:0] out : first requesting lane in search order (0 when none)
module rr_pick8
    import demux8_sched_pkg::*;
(
    input  logic [NUM_LANES-1:0] req,
    input  logic [SEL_W-1:0]     ptr,
    output logic                 found,
    output logic [SEL_W-1:0]     idx
);

    logic [SEL_W-1:0] cand_s;

    // Walk the search order from farthest to nearest so the nearest hit is written last.
    always_comb begin
        found  = |req;
        idx    = 3'd0;
        cand_s = 3'd0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            cand_s = ptr + 3'(i);
            idx    = req[cand_s] ? cand_s : idx;
        end
    end

endmodule

// File: rtl/demux8_rr_sched.sv
// Sequencing controller for the 1:8 demultiplexer datapath. Accepts words on a
// valid/ready input, holds one word in an output register and delivers it to one
// of eight lanes chosen by round-robin over enabled lanes or by in_dest.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : producer handshake (in_ready is combinational)
//   in_data, in_dest      : word and directed destination lane
//   rr_mode               : 1 = round-robin choice, 0 = directed by in_dest
//   lane_en               : per-lane enable mask
//   out_data/out_sel      : held word and its lane (registered)
//   out_valid/out_ready   : one-hot lane valid (registered) and per-lane ready
//   xfer_cnt/drop_cnt     : delivered words / directed words dropped, wrapping
module demux8_rr_sched
    import demux8_sched_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [SEL_W-1:0]     in_dest,
    input  logic                 rr_mode,
    input  logic [NUM_LANES-1:0] lane_en,
    output logic [DATA_W-1:0]    out_data,
    output logic [SEL_W-1:0]     out_sel,
    output logic [NUM_LANES-1:0] out_valid,
    input  logic [NUM_LANES-1:0] out_ready,
    output logic [CNT_W-1:0]     xfer_cnt,
    output logic [CNT_W-1:0]     drop_cnt
);

    sched_state_e          state_r, state_nxt_s;
    logic [SEL_W-1:0]      ptr_r;
    logic [DATA_W-1:0]     data_r;
    logic [SEL_W-1:0]      sel_r, sel_nxt_s;
    logic [NUM_LANES-1:0]  valid_r, valid_nxt_s;
    logic [CNT_W-1:0]      xfer_r, drop_r;

    logic                  pick_found_s;
    logic [SEL_W-1:0]      pick_idx_s;
    logic                  deliver_s, slot_free_s, ready_s, accept_s, load_s, drop_s;
    logic [SEL_W-1:0]      target_s;

    rr_pick8 u_pick (
        .req   (lane_en),
        .ptr   (ptr_r),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Handshake, delivery and load/drop decisions for the current cycle.
    always_comb begin
        deliver_s   = (state_r == HOLD) && out_ready[sel_r];
        slot_free_s = (state_r == IDLE) || deliver_s;
        if (rr_mode) begin
            ready_s  = pick_found_s && slot_free_s;
            target_s = pick_idx_s;
            accept_s = in_valid && ready_s;
            load_s   = accept_s;
            drop_s   = 1'b0;
        end else begin
            ready_s  = slot_free_s;
            target_s = in_dest;
            accept_s = in_valid && ready_s;
            // A directed word for a disabled lane is consumed but never held.
            load_s   = accept_s && lane_en[in_dest];
            drop_s   = accept_s && !lane_en[in_dest];
        end
    end

    // Next state, next lane and next one-hot valid.
    always_comb begin
        state_nxt_s = state_r;
        sel_nxt_s   = sel_r;
        case (state_r)
            IDLE: begin
                if (load_s) begin
                    state_nxt_s = HOLD;
                    sel_nxt_s   = target_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HOLD: begin
                if (load_s) begin
                    state_nxt_s = HOLD;
                    sel_nxt_s   = target_s;
                end else if (deliver_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        valid_nxt_s = (state_nxt_s == HOLD) ? lane_onehot(sel_nxt_s) : 8'h00;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Output registers, round-robin pointer and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r   <= 3'd0;
            data_r  <= '0;
            sel_r   <= 3'd0;
            valid_r <= 8'h00;
            xfer_r  <= '0;
            drop_r  <= '0;
        end else begin
            sel_r   <= sel_nxt_s;
            valid_r <= valid_nxt_s;
            if (load_s) begin
                data_r <= in_data;
            end
            // Only round-robin loads move the pointer past the chosen lane.
            if (load_s && rr_mode) begin
                ptr_r <= target_s + 3'd1;
            end
            if (deliver_s) begin
                xfer_r <= xfer_r + CNT_W'(1);
            end
            if (drop_s) begin
                drop_r <= drop_r + CNT_W'(1);
            end
        end
    end

    assign in_ready  = rst_n && ready_s;
    assign out_data  = data_r;
    assign out_sel   = sel_r;
    assign out_valid = valid_r;
    assign xfer_cnt  = xfer_r;
    assign drop_cnt  = drop_r;

endmodule
